// File: rtl/jtag_pkg.sv
// jtag_pkg
// Shared definitions for the JTAG test logic: instruction opcodes, the
// IR capture pattern, the DR selection type and the TAP state encoding
// used by the TAP controller that drives the strobes into this block.
package jtag_pkg;

  localparam logic [3:0] IR_IDCODE  = 4'h1;
  localparam logic [3:0] IR_USER    = 4'h8;
  localparam logic [3:0] IR_BYPASS  = 4'hF;
  // Low two bits 01 are what the standard mandates on IR capture.
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  // Standard TAP state encoding, shared with the TAP controller.
  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  // Map an opcode to the data register it selects; anything unknown
  // falls back to BYPASS.
  function automatic dr_sel_e decode_ir(input logic [3:0] op);
    case (op)
      IR_IDCODE: return SEL_IDCODE;
      IR_USER:   return SEL_USER;
      default:   return SEL_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg
// Generic JTAG shift register: parallel capture, then right shift with
// the serial input entering at the MSB (LSB leaves first).
// Ports:
//   clk, rst  - clock (rising edge) and async active-high reset
//   cap       - load cap_val (wins over shift)
//   shift     - shift si in at the MSB
//   si        - serial input
//   cap_val   - parallel capture value
//   q         - register contents
module jtag_shift_reg #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap,
  input  logic         shift,
  input  logic         si,
  input  logic [W-1:0] cap_val,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (cap) begin
      q <= cap_val;
    end else if (shift) begin
      q <= {si, q[W-1:1]};
    end
  end

endmodule

// File: rtl/jtag_tdr_block.sv
// jtag_tdr_block
// Instruction register and test-data-register bank (BYPASS, IDCODE,
// USER) sitting behind the TAP controller.
// Ports:
//   tck, trst        - JTAG clock and async active-high reset
//   tdi              - serial data in
//   cdr/sdr/udr      - TAP capture/shift/update DR strobes
//   cir/sir/uir      - TAP capture/shift/update IR strobes
//   user_cap         - parallel value captured into USER
//   tdo, tdo_oe      - serial data out and its drive enable
//   ir_out           - active instruction
//   user_upd         - last value transferred out of USER on update
//   user_upd_vld     - one-cycle pulse when user_upd is written
module jtag_tdr_block
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          USER_W     = 16,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5A5B
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tdi,
  input  logic              cdr,
  input  logic              sdr,
  input  logic              udr,
  input  logic              cir,
  input  logic              sir,
  input  logic              uir,
  input  logic [USER_W-1:0] user_cap,
  output logic              tdo,
  output logic              tdo_oe,
  output logic [IR_W-1:0]   ir_out,
  output logic [USER_W-1:0] user_upd,
  output logic              user_upd_vld
);

  if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
    $error("jtag_tdr_block: IDCODE_VAL bit 0 must be 1");
  end

  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(IR_IDCODE);
  localparam logic [IR_W-1:0] OP_USER   = IR_W'(IR_USER);
  localparam logic [IR_W-1:0] OP_CAP    = IR_W'(IR_CAPTURE);

  logic [IR_W-1:0]   ir_sr;
  logic [USER_W-1:0] usr_sr;
  logic              id_so;
  logic [31:1]       id_hi_unused;
  logic              byp;
  dr_sel_e           sel;

  // Decoded from the registered IR, so a DR op coincident with uir still
  // sees the previous instruction.
  always_comb begin
    sel = SEL_BYPASS;
    if (ir_out == OP_IDCODE)    sel = SEL_IDCODE;
    else if (ir_out == OP_USER) sel = SEL_USER;
  end

  jtag_shift_reg #(.W(IR_W), .RST_VAL(OP_CAP)) u_ir_sr (
    .clk     (tck),
    .rst     (trst),
    .cap     (cir),
    .shift   (sir),
    .si      (tdi),
    .cap_val (OP_CAP),
    .q       (ir_sr)
  );

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_out <= OP_IDCODE;
    end else if (uir && !cir && !sir) begin
      ir_out <= ir_sr;
    end
  end

  // Only the LSB of IDCODE is ever observed; the rest just shifts down.
  jtag_shift_reg #(.W(32), .RST_VAL(32'h0)) u_id_sr (
    .clk     (tck),
    .rst     (trst),
    .cap     (cdr && sel == SEL_IDCODE),
    .shift   (sdr && sel == SEL_IDCODE),
    .si      (tdi),
    .cap_val (IDCODE_VAL),
    .q       ({id_hi_unused, id_so})
  );

  jtag_shift_reg #(.W(USER_W), .RST_VAL('0)) u_usr_sr (
    .clk     (tck),
    .rst     (trst),
    .cap     (cdr && sel == SEL_USER),
    .shift   (sdr && sel == SEL_USER),
    .si      (tdi),
    .cap_val (user_cap),
    .q       (usr_sr)
  );

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      byp <= 1'b0;
    end else if (sel == SEL_BYPASS) begin
      if (cdr)      byp <= 1'b0;
      else if (sdr) byp <= tdi;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      user_upd     <= '0;
      user_upd_vld <= 1'b0;
    end else begin
      user_upd_vld <= 1'b0;
      if (udr && !cdr && !sdr && sel == SEL_USER) begin
        user_upd     <= usr_sr;
        user_upd_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (sir) begin
      tdo = ir_sr[0];
    end else if (sdr) begin
      case (sel)
        SEL_IDCODE: tdo = id_so;
        SEL_USER:   tdo = usr_sr[0];
        default:    tdo = byp;
      endcase
    end
  end

  assign tdo_oe = sir | sdr;

endmodule

// File: tb/tb_jtag_tdr_block.sv
module tb_jtag_tdr_block;

  logic        tck = 1'b0;
  logic        trst;
  logic        tdi, cdr, sdr, udr, cir, sir, uir;
  logic [15:0] user_cap;
  logic        tdo, tdo_oe;
  logic [3:0]  ir_out;
  logic [15:0] user_upd;
  logic        user_upd_vld;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_tdo_q[$];
  logic [15:0] exp_upd_q[$];

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_CIR  = 6'b100000;
  localparam logic [5:0] S_SIR  = 6'b010000;
  localparam logic [5:0] S_UIR  = 6'b001000;
  localparam logic [5:0] S_CDR  = 6'b000100;
  localparam logic [5:0] S_SDR  = 6'b000010;
  localparam logic [5:0] S_UDR  = 6'b000001;

  jtag_tdr_block dut (
    .tck          (tck),
    .trst         (trst),
    .tdi          (tdi),
    .cdr          (cdr),
    .sdr          (sdr),
    .udr          (udr),
    .cir          (cir),
    .sir          (sir),
    .uir          (uir),
    .user_cap     (user_cap),
    .tdo          (tdo),
    .tdo_oe       (tdo_oe),
    .ir_out       (ir_out),
    .user_upd     (user_upd),
    .user_upd_vld (user_upd_vld)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, whenever the DUT drives TDO or pulses
  // user_upd_vld, and compares against the head of the matching queue.
  always @(negedge tck) begin
    if (!trst) begin
      if (tdo_oe) begin
        if (exp_tdo_q.size() == 0) chk("tdo_unexpected", 32'(tdo_oe), 32'h0);
        else chk("tdo_bit", 32'(tdo), 32'(exp_tdo_q.pop_front()));
      end
      if (user_upd_vld) begin
        if (exp_upd_q.size() == 0) chk("upd_vld_unexpected", 32'(user_upd_vld), 32'h0);
        else chk("user_upd", 32'(user_upd), 32'(exp_upd_q.pop_front()));
      end
    end
  end

  // One TCK cycle with the given strobes; e is the TDO bit expected while
  // a shift strobe is active.
  task automatic tick(input logic [5:0] s, input logic t, input logic e);
    {cir, sir, uir, cdr, sdr, udr} = s;
    tdi = t;
    if (s[4] | s[1]) exp_tdo_q.push_back(e);
    @(posedge tck);
    #1;
  endtask

  // Load an opcode into the IR; capture pattern 0101 comes out first.
  task automatic load_ir(input logic [3:0] op);
    logic [3:0] capv;
    capv = 4'b0101;
    tick(S_CIR, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(S_SIR, op[i], capv[i]);
    tick(S_UIR, 1'b0, 1'b0);
    tick(S_IDLE, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] idv;
    logic [15:0] capv, shv;
    logic [3:0]  pat;
    idv  = 32'h1234_5A5B;
    trst = 1'b1;
    {cir, sir, uir, cdr, sdr, udr} = 6'b0;
    tdi = 1'b0;
    user_cap = 16'h0;
    repeat (2) @(posedge tck);
    #1;
    chk("rst_ir_out", 32'(ir_out), 32'h1);
    chk("rst_user_upd", 32'(user_upd), 32'h0);
    chk("rst_vld", 32'(user_upd_vld), 32'h0);
    chk("rst_tdo_oe", 32'(tdo_oe), 32'h0);
    chk("rst_tdo", 32'(tdo), 32'h0);
    trst = 1'b0;
    tick(S_IDLE, 1'b0, 1'b0);

    // IDCODE selected by default
    tick(S_CDR, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) tick(S_SDR, 1'b0, idv[i]);
    tick(S_IDLE, 1'b0, 1'b0);
    chk("idle_tdo_oe", 32'(tdo_oe), 32'h0);
    chk("ir_default", 32'(ir_out), 32'h1);

    // IR <- F
    load_ir(4'hF);
    chk("ir_bypass", 32'(ir_out), 32'hF);

    // BYPASS: 1,0,1,1 in -> 0,1,0,1 out
    tick(S_CDR, 1'b0, 1'b0);
    tick(S_SDR, 1'b1, 1'b0);
    tick(S_SDR, 1'b0, 1'b1);
    tick(S_SDR, 1'b1, 1'b0);
    tick(S_SDR, 1'b1, 1'b1);
    tick(S_IDLE, 1'b0, 1'b0);

    // USER: capture BEEF, shift in 1357, update
    load_ir(4'h8);
    chk("ir_user", 32'(ir_out), 32'h8);
    capv = 16'hBEEF;
    shv  = 16'h1357;
    user_cap = capv;
    tick(S_CDR, 1'b0, 1'b0);
    user_cap = 16'h0;
    for (int i = 0; i < 16; i++) tick(S_SDR, shv[i], capv[i]);
    exp_upd_q.push_back(16'h1357);
    tick(S_UDR, 1'b0, 1'b0);
    tick(S_IDLE, 1'b0, 1'b0);
    tick(S_IDLE, 1'b0, 1'b0);
    chk("user_upd_hold", 32'(user_upd), 32'h1357);
    chk("upd_vld_low", 32'(user_upd_vld), 32'h0);

    // Unknown opcode 3 behaves as BYPASS
    load_ir(4'h3);
    chk("ir_unknown", 32'(ir_out), 32'h3);
    pat = 4'b1101;
    tick(S_CDR, 1'b0, 1'b0);
    tick(S_SDR, pat[0], 1'b0);
    tick(S_SDR, pat[1], pat[0]);
    tick(S_SDR, pat[2], pat[1]);
    tick(S_SDR, pat[3], pat[2]);
    tick(S_IDLE, 1'b0, 1'b0);

    // Reset in the middle of a USER shift
    load_ir(4'h8);
    user_cap = capv;
    tick(S_CDR, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(S_SDR, shv[i], capv[i]);
    {cir, sir, uir, cdr, sdr, udr} = 6'b0;
    #1 trst = 1'b1;
    #1;
    chk("midrst_ir_out", 32'(ir_out), 32'h1);
    chk("midrst_user_upd", 32'(user_upd), 32'h0);
    chk("midrst_tdo_oe", 32'(tdo_oe), 32'h0);
    chk("midrst_vld", 32'(user_upd_vld), 32'h0);
    @(posedge tck);
    #1 trst = 1'b0;
    tick(S_UDR, 1'b0, 1'b0);
    tick(S_IDLE, 1'b0, 1'b0);
    tick(S_IDLE, 1'b0, 1'b0);
    chk("post_udr_user_upd", 32'(user_upd), 32'h0);
    chk("post_udr_ir_out", 32'(ir_out), 32'h1);

    chk("tdo_queue_drained", 32'(exp_tdo_q.size()), 32'h0);
    chk("upd_queue_drained", 32'(exp_upd_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tdr_block.md
Name: jtag_tdr_block

Overview:
- Instruction register plus test-data-register bank for the JTAG port.
- Sits directly downstream of the TAP controller and consumes its one-hot state strobes: capture/shift/update for the DR and IR paths.
- Drives TDO and exposes one user data register to core logic.
- Holds the IR, plus the BYPASS, IDCODE and USER data registers.

Parameters:
- IR_W, 4, instruction register width in bits.
- USER_W, 16, USER data register width in bits.
- IDCODE_VAL, 32'h1234_5A5B, value loaded into IDCODE on capture. Bit 0 must be 1; elaboration error otherwise.

Ports:
- tck  input  1  JTAG clock; all state changes on its rising edge.
- trst  input  1  asynchronous, active-high reset.
- tdi  input  1  serial data in.
- cdr  input  1  TAP in CAPTURE_DR.
- sdr  input  1  TAP in SHIFT_DR.
- udr  input  1  TAP in UPDATE_DR.
- cir  input  1  TAP in CAPTURE_IR.
- sir  input  1  TAP in SHIFT_IR.
- uir  input  1  TAP in UPDATE_IR.
- user_cap  input  USER_W  parallel value captured into the USER register.
- tdo  output  1  serial data out.
- tdo_oe  output  1  TDO drive enable.
- ir_out  output  IR_W  currently active instruction.
- user_upd  output  USER_W  last updated USER value.
- user_upd_vld  output  1  one-cycle pulse when user_upd is written.

Behaviour:
- Reset (trst=1, asynchronous):
  - ir_sr = 4'b0101; ir_out = IDCODE (4'h1).
  - id_sr = 0; byp = 0; usr_sr = 0; user_upd = 0; user_upd_vld = 0.
- Reset mid-shift aborts the shift; no update occurs.
- Instruction decode (active IR = ir_out):
  - 4'h1 selects IDCODE.
  - 4'h8 selects USER.
  - 4'hF and every other code select BYPASS.
- IR path, priority cir > sir > uir:
  - cir: ir_sr <= 4'b0101 (low bits 01 per standard).
  - sir: ir_sr <= {tdi, ir_sr[IR_W-1:1]}, LSB shifted out first.
  - uir: ir_out <= ir_sr.
- DR path, priority cdr > sdr > udr; only the selected register changes:
  - cdr, IDCODE selected: id_sr <= IDCODE_VAL.
  - cdr, BYPASS selected: byp <= 0.
  - cdr, USER selected: usr_sr <= user_cap (sampled at this edge).
  - sdr: selected register <= {tdi, reg[N-1:1]}. For BYPASS, byp <= tdi.
  - udr with USER selected: user_upd <= usr_sr and user_upd_vld = 1 for exactly the next cycle.
  - udr with IDCODE or BYPASS selected: no effect.
- The IR and DR groups are independent. The TAP guarantees mutual exclusion; priority applies only if strobes collide.
- A change of ir_out takes effect from the cycle after uir. A DR op in the same cycle as uir uses the old ir_out.
- TDO output (combinational):
  - sir: tdo = ir_sr[0].
  - sdr: tdo = LSB of the selected register (byp for BYPASS).
  - otherwise tdo = 0.
  - tdo_oe = sir | sdr.
- Latency: a bit presented on tdi during sdr appears on tdo:
  - after 1 edge for BYPASS;
  - after USER_W edges for USER;
  - after 32 edges for IDCODE.
- Shifting more bits than the register width passes tdi straight through, i.e. the register acts as a shift pipe of its width. No wrap-around.
- user_upd_vld goes high on the edge where udr=1 with USER selected and low on the next edge.

Decomposition:
- jtag_pkg holds:
  - IR opcode constants: IR_IDCODE=4'h1, IR_USER=4'h8, IR_BYPASS=4'hF.
  - IR_CAPTURE=4'b0101.
  - The TAP state encoding shared with the TAP controller.
- One natural sub-module: jtag_shift_reg, parameterised width, with capture, shift and parallel load. It is instantiated for IR, IDCODE and USER.

Test Plan:
- Reset, then DR capture and 32 shifts with the default IR → tdo serially yields 0x1234_5A5B LSB first; ir_out = 4'h1.
- IR capture, then shift 4 bits of 4'hF (tdi=1 ×4), then uir → first 4 tdo bits are 1,0,1,0; ir_out = 4'hF.
- BYPASS: cdr, then shift tdi pattern 1,0,1,1 → tdo = 0,1,0,1 (one-cycle delay, first bit 0).
- USER: IR = 4'h8, user_cap = 16'hBEEF, cdr, then shift in 16'h1357 over 16 cycles, then udr →
  - tdo streams 0xBEEF LSB first;
  - user_upd = 16'h1357;
  - user_upd_vld high for exactly 1 cycle.
- Unknown IR 4'h3 → behaves as BYPASS (1-cycle delay).
- Assert trst mid-USER-shift (after 8 bits) → outputs return to reset values immediately; later udr without recapture gives user_upd = 0 with ir_out = IDCODE, so no user_upd_vld pulse.
